// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> M-extension sequencer handshake and operand bus.
// Signal suffixes are from the sequencer's point of view.
interface muldiv_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  // Execute stage / pipeline control side
  modport master (
    output start_i, funct3_i, op_a_i, op_b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  // Sequencer side
  modport slave (
    input  start_i, funct3_i, op_a_i, op_b_i, flush_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide over XLEN iterations on operand magnitudes, sign fix-up at the end.
// Optional macro MULDIV_FASTPATH_EN: zero-operand multiply, divide-by-zero and
// signed DIV overflow bypass the iteration and finish two cycles after launch.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            res_neg_q, res_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_trial;
  logic [PW-1:0]   acc_neg;
  logic [XLEN-1:0] hi_neg;
  logic [PW-1:0]   prod;

  // Next-state, datapath step and output selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    b_d       = b_q;
    acc_d     = acc_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;

    a_signed  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b010) ||
                (bus.funct3_i == 3'b100) || (bus.funct3_i == 3'b110);
    b_signed  = (bus.funct3_i == 3'b001) || (bus.funct3_i == 3'b100) ||
                (bus.funct3_i == 3'b110);
    a_neg     = a_signed & bus.op_a_i[XLEN-1];
    b_neg     = b_signed & bus.op_b_i[XLEN-1];
    a_mag     = a_neg ? (~bus.op_a_i + XLEN'(1)) : bus.op_a_i;
    b_mag     = b_neg ? (~bus.op_b_i + XLEN'(1)) : bus.op_b_i;

    // Upper product half plus multiplicand, carry kept for the right shift
    mul_sum   = {1'b0, acc_q[PW-1:XLEN]} + {1'b0, b_q};
    // Remainder shifted left by one (XLEN+1 bits) minus divisor
    div_trial = acc_q[PW-1:XLEN-1] - {1'b0, b_q};
    acc_neg   = ~acc_q + PW'(1);
    hi_neg    = ~acc_q[PW-1:XLEN] + XLEN'(1);
    prod      = res_neg_q ? acc_neg : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          funct3_d = bus.funct3_i;
          b_d      = b_mag;
          acc_d    = {XLEN'(0), a_mag};
          cnt_d    = '0;
          if (bus.funct3_i[2]) begin
            // Divide by zero keeps the all-ones quotient unsigned
            res_neg_d = (a_neg ^ b_neg) & (bus.op_b_i != '0);
            rem_neg_d = a_neg;
            state_d   = S_DIV;
          end else begin
            res_neg_d = a_neg ^ b_neg;
            rem_neg_d = 1'b0;
            state_d   = S_MUL;
          end
`ifdef MULDIV_FASTPATH_EN
          if (!bus.funct3_i[2] && ((bus.op_a_i == '0) || (bus.op_b_i == '0))) begin
            acc_d   = '0;
            state_d = S_FIX;
          end else if (bus.funct3_i[2] && (bus.op_b_i == '0)) begin
            acc_d   = {a_mag, {XLEN{1'b1}}};
            state_d = S_FIX;
          end else if ((bus.funct3_i == 3'b100) &&
                       (bus.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (bus.op_b_i == {XLEN{1'b1}})) begin
            // |a| is already 2^(XLEN-1): quotient = |a|, remainder = 0
            acc_d   = {XLEN'(0), a_mag};
            state_d = S_FIX;
          end
`endif
        end
      end
      S_MUL: begin
        if (acc_q[0]) acc_d = {mul_sum, acc_q[XLEN-1:1]};
        else          acc_d = {1'b0, acc_q[PW-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
        if (bus.flush_i) state_d = S_IDLE;
      end
      S_DIV: begin
        if (!div_trial[XLEN]) acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else                  acc_d = {acc_q[PW-2:0], 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
        if (bus.flush_i) state_d = S_IDLE;
      end
      S_FIX: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
        end else begin
          if (!funct3_q[2]) begin
            result_d = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
          end else if (!funct3_q[1]) begin
            result_d = prod[XLEN-1:0];
          end else begin
            result_d = rem_neg_q ? hi_neg : acc_q[PW-1:XLEN];
          end
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors, latency,
// flush, reset and handshake checks.
module tb_muldiv_sequencer;

  localparam int unsigned XLEN = 32;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  int   last_done_cyc;
  sb_t  exp_q[$];

  muldiv_sequencer_if #(.XLEN(XLEN)) bus ();

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pop the expected result whenever done_o is presented
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done_o) begin
        done_cnt++;
        last_done_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_done", bus.result_o, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check(e.name, bus.result_o, e.exp);
        end
      end
    end
  end

  // Cycle N+k is the cycle ending at edge N+k, so done seen after edge N+33 is latency 34
  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (!f[2] && ((a == 0) || (b == 0))) return 2;
    if (f[2] && (b == 0)) return 2;
    if ((f == 3'b100) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
`endif
    return 34;
  endfunction

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lc);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.funct3_i = f;
    bus.op_a_i   = a;
    bus.op_b_i   = b;
    @(posedge clk);
    #1;
    lc = cyc;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != d0) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    int lc;
    int d0;
    sb_t e;
    e.name = name;
    e.exp  = exp;
    d0 = done_cnt;
    exp_q.push_back(e);
    launch(f, a, b, lc);
    wait_done(name, d0);
    check({name, "_lat"}, 32'(last_done_cyc - lc + 1), 32'(exp_lat(f, a, b)));
  endtask

  initial begin
    int lc;
    int lc2;
    int d0;
    int d1cyc;
    logic [31:0] held;
    sb_t e;

    total = 0; bad = 0; cyc = 0; done_cnt = 0; last_done_cyc = 0;
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.funct3_i = 3'b000; bus.op_a_i = '0; bus.op_b_i = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    check("rst_done",   32'(bus.done_o), 32'd0);
    check("rst_result", bus.result_o,    32'd0);

    run("mul",    3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run("mulh",   3'b001, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run("mulhu",  3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);
    run("mulhsu", 3'b010, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF);
    run("mulhsu_pos", 3'b010, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006);
    run("mul_zero", 3'b000, 32'd0, 32'hFFFF_FFFD, 32'h0000_0000);
    run("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu",   3'b101, 32'd100, 32'd7, 32'd14);
    run("remu",   3'b111, 32'd100, 32'd7, 32'd2);
    run("div_by0",  3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("rem_by0",  3'b110, 32'd5, 32'd0, 32'd5);
    run("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("divn_by0", 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
    run("remn_by0", 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    run("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

    // start_i held high across a whole DIVU: exactly one completion
    e.name = "held_divu"; e.exp = 32'd14;
    exp_q.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    wait_done("held_divu", d0);
    bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("held_one_done", 32'(done_cnt - d0), 32'd1);

    // Flush ten edges after launch: abort, no done, result kept
    held = bus.result_o;
    d0 = done_cnt;
    launch(3'b100, 32'hFFFF_FFF9, 32'd2, lc);
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy", 32'(bus.busy_o), 32'd0);
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt), 32'(d0));
    check("flush_result",  bus.result_o, held);

    // Flush and start together in IDLE: no launch
    @(negedge clk);
    bus.start_i = 1'b1; bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0; bus.flush_i = 1'b0;
    check("flush_start_busy", 32'(bus.busy_o), 32'd0);

    // Back-to-back: second start offered during DONE, accepted in the next IDLE cycle
    e.name = "b2b_mul"; e.exp = 32'hFFFF_FFEB;
    exp_q.push_back(e);
    d0 = done_cnt;
    launch(3'b000, 32'd7, 32'hFFFF_FFFD, lc);
    wait_done("b2b_mul", d0);
    d1cyc = last_done_cyc;
    e.name = "b2b_divu"; e.exp = 32'd14;
    exp_q.push_back(e);
    d0 = done_cnt;
    bus.start_i = 1'b1; bus.funct3_i = 3'b101; bus.op_a_i = 32'd100; bus.op_b_i = 32'd7;
    @(posedge clk);
    @(posedge clk);
    #1;
    lc2 = cyc;
    bus.start_i = 1'b0;
    wait_done("b2b_divu", d0);
    check("b2b_launch_gap", 32'(lc2 - lc), 32'd35);
    check("b2b_done_gap",   32'(last_done_cyc - d1cyc), 32'd35);

    // Asynchronous reset in the middle of a DIV
    launch(3'b100, 32'hFFFF_FFF9, 32'd2, lc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy_o), 32'd0);
    check("arst_done",   32'(bus.done_o), 32'd0);
    check("arst_result", bus.result_o,    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst_remu", 3'b111, 32'd100, 32'd7, 32'd2);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
